dp_ram_nr_1w_clr: RTL and testbench

DP_RAM_NR_1W_CLR -- requirements
Module: dp_ram_nr_1w_clr

---
 rtl/dp_ram_nr_1w_clr.sv | 112 +++++++++++
 tb/tb_dp_ram_nr_1w_clr.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dp_ram_nr_1w_clr.sv
// Multi-read, single-write RAM with byte enables and a self-sequencing clear engine.
// State | meaning:  ST_CLEAR | engine sweeping CLR_VALUE over the array, ports ignored;  ST_READY | normal read/write
module dp_ram_nr_1w_clr #(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    NUM_RD     = 2,
    parameter int                    WR_FIRST   = 1,
    parameter logic [DATA_WIDTH-1:0] CLR_VALUE  = '0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [DATA_WIDTH-1:0]        WR_DI,
    input  logic [ADDR_WIDTH-1:0]        WR_ADDR,
    input  logic                         WR_EN,
    input  logic [DATA_WIDTH/8-1:0]      WR_BE,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] RD_ADDR,
    input  logic [NUM_RD-1:0]            RD_EN,
    output logic [NUM_RD*DATA_WIDTH-1:0] RD_DO,
    output logic [NUM_RD-1:0]            RD_VLD,
    input  logic                         CLR_REQ,
    output logic                         BUSY
);

    localparam int DEPTH     = 2 ** ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    ready;
    logic                    wr_act;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (&clr_cnt) state_nxt = ST_READY;
            end
            ST_READY: begin
                if (CLR_REQ) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: state_nxt = ST_CLEAR;
        endcase
    end

    assign ready  = (state == ST_READY);
    assign wr_act = ready & WR_EN;
    assign BUSY   = (state == ST_CLEAR);

    // The array itself is never reset; it only becomes CLR_VALUE through the sweep.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            if (state == ST_CLEAR) begin
                mem[clr_cnt] <= CLR_VALUE;
            end else if (WR_EN) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (WR_BE[b]) mem[WR_ADDR][8*b +: 8] <= WR_DI[8*b +: 8];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] word;
        logic [DATA_WIDTH-1:0] do_q;
        logic                  vld_q;

        assign addr = RD_ADDR[p*ADDR_WIDTH +: ADDR_WIDTH];

        // Write-first bypass merges the enabled incoming bytes over the stored word.
        always_comb begin
            word = mem[addr];
            if (WR_FIRST != 0 && wr_act && WR_ADDR == addr) begin
                for (int b = 0; b < NUM_BYTES; b++) begin
                    if (WR_BE[b]) word[8*b +: 8] = WR_DI[8*b +: 8];
                end
            end
        end

        always_ff @(posedge CLK or posedge RST) begin
            if (RST) begin
                do_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= ready & RD_EN[p];
                if (ready && RD_EN[p]) do_q <= word;
            end
        end

        assign RD_DO[p*DATA_WIDTH +: DATA_WIDTH] = do_q;
        assign RD_VLD[p]                         = vld_q;
    end

endmodule

// File: tb/tb_dp_ram_nr_1w_clr.sv
// Randomized self-checking bench for dp_ram_nr_1w_clr against an array-based reference model.
module tb_dp_ram_nr_1w_clr;

    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int NR    = 2;
    localparam int WRF   = 1;
    localparam int DEPTH = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [DW-1:0]   wr_di = '0;
    logic [AW-1:0]   wr_addr = '0;
    logic            wr_en = 1'b0;
    logic [1:0]      wr_be = '0;
    logic [NR*AW-1:0] rd_addr = '0;
    logic [NR-1:0]   rd_en = '0;
    logic [NR*DW-1:0] rd_do;
    logic [NR-1:0]   rd_vld;
    logic            clr_req = 1'b0;
    logic            busy;

    logic [DW-1:0]    m [DEPTH];
    int               clr_left;
    logic [NR*DW-1:0] exp_do;
    logic [NR-1:0]    exp_vld;

    int vectors = 0;
    int miscompares = 0;

    dp_ram_nr_1w_clr #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_RD(NR), .WR_FIRST(WRF), .CLR_VALUE(16'h0000)
    ) dut (
        .CLK(clk), .RST(rst), .WR_DI(wr_di), .WR_ADDR(wr_addr), .WR_EN(wr_en), .WR_BE(wr_be),
        .RD_ADDR(rd_addr), .RD_EN(rd_en), .RD_DO(rd_do), .RD_VLD(rd_vld),
        .CLR_REQ(clr_req), .BUSY(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] di,
                                            input logic [1:0] be);
        logic [DW-1:0] r;
        r = old;
        if (be[0]) r[7:0]  = di[7:0];
        if (be[1]) r[15:8] = di[15:8];
        return r;
    endfunction

    task automatic model_reset();
        clr_left = DEPTH;
        exp_do   = '0;
        exp_vld  = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs the bench is driving.
    task automatic model_step();
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        if (rst) begin
            model_reset();
        end else if (clr_left > 0) begin
            m[DEPTH - clr_left] = 16'h0000;
            clr_left--;
            exp_vld = '0;
        end else begin
            for (int p = 0; p < NR; p++) begin
                if (rd_en[p]) begin
                    a = rd_addr[p*AW +: AW];
                    w = m[a];
                    if (WRF != 0 && wr_en && wr_addr == a) w = merge(w, wr_di, wr_be);
                    exp_do[p*DW +: DW] = w;
                end
            end
            exp_vld = rd_en;
            if (wr_en) m[wr_addr] = merge(m[wr_addr], wr_di, wr_be);
            if (clr_req) clr_left = DEPTH;
        end
    endtask

    always @(negedge clk) begin
        vectors++;
        if (busy !== (clr_left != 0) || rd_vld !== exp_vld || rd_do !== exp_do) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0t busy=%b want %b vld=%b want %b do=%h want %h",
                     $time, busy, (clr_left != 0), rd_vld, exp_vld, rd_do, exp_do);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s got %h want %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        wr_be   = '0;
        rd_en   = '0;
        clr_req = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
        wr_addr = a; wr_di = d; wr_be = be; wr_en = 1'b1;
        tick();
        idle();
    endtask

    task automatic do_read(input logic [NR-1:0] en, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_en = en; rd_addr = {a1, a0};
        tick();
        idle();
    endtask

    task automatic count_busy(input string name);
        int n;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        check(name, n, 16);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) m[i] = 16'h0000;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) tick();
        check("reset_busy", {31'd0, busy}, 32'd1);
        check("reset_vld", {30'd0, rd_vld}, 32'd0);
        check("reset_do", rd_do, 32'd0);

        rst = 1'b0;
        count_busy("busy_after_reset");

        for (int i = 0; i < DEPTH; i++) do_read(2'b11, AW'(i), AW'(15 - i));
        check("init_read_do", rd_do, 32'd0);
        check("init_read_vld", {30'd0, rd_vld}, 32'd3);

        do_write(4'd3, 16'hA5C3, 2'b11);
        do_write(4'd3, 16'h1200, 2'b10);
        do_read(2'b01, 4'd3, 4'd0);
        check("be_merge_addr3", {16'd0, rd_do[15:0]}, 32'h12C3);

        do_write(4'd5, 16'h1111, 2'b11);
        do_read(2'b10, 4'd0, 4'd5);
        check("p1_read_addr5", {16'd0, rd_do[31:16]}, 32'h1111);
        do_read(2'b01, 4'd3, 4'd9);
        check("p0_indep_do", {16'd0, rd_do[15:0]}, 32'h12C3);
        check("p1_hold_do", {16'd0, rd_do[31:16]}, 32'h1111);
        check("p1_hold_vld", {30'd0, rd_vld}, 32'd1);

        wr_addr = 4'd5; wr_di = 16'h2222; wr_be = 2'b11; wr_en = 1'b1;
        rd_en = 2'b01; rd_addr = {4'd0, 4'd5};
        tick();
        idle();
        check("collision", {16'd0, rd_do[15:0]}, (WRF != 0) ? 32'h2222 : 32'h1111);
        do_read(2'b01, 4'd5, 4'd0);
        check("after_collision", {16'd0, rd_do[15:0]}, 32'h2222);

        for (int i = 0; i < 300; i++) begin
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = AW'($urandom_range(0, 15));
            wr_di   = DW'($urandom);
            wr_be   = 2'($urandom_range(0, 3));
            rd_en   = 2'($urandom_range(0, 3));
            rd_addr = {AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15))};
            clr_req = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle();
        begin
            int n;
            n = 0;
            while (busy && n < 40) begin
                n++;
                tick();
            end
            check("drain_busy_bound", {31'd0, busy}, 32'd0);
        end

        do_write(4'd2, 16'h7777, 2'b11);
        clr_req = 1'b1;
        tick();
        idle();
        wr_en = 1'b1; wr_addr = 4'd2; wr_di = 16'hFFFF; wr_be = 2'b11;
        count_busy("busy_after_clr_req");
        idle();
        for (int i = 0; i < DEPTH; i++) begin
            do_read(2'b11, AW'(i), AW'((i + 1) % DEPTH));
            if (i == 2) check("addr2_cleared", {16'd0, rd_do[15:0]}, 32'd0);
        end

        do_write(4'd7, 16'hBEEF, 2'b11);
        do_read(2'b01, 4'd7, 4'd0);
        check("pre_rst_do", {16'd0, rd_do[15:0]}, 32'hBEEF);
        clr_req = 1'b1;
        tick();
        idle();
        repeat (7) tick();
        #1 rst = 1'b1;
        model_reset();
        #1;
        check("async_rst_busy", {31'd0, busy}, 32'd1);
        check("async_rst_do", rd_do, 32'd0);
        check("async_rst_vld", {30'd0, rd_vld}, 32'd0);
        repeat (2) tick();
        rst = 1'b0;
        count_busy("busy_after_mid_rst");
        do_read(2'b11, 4'd7, 4'd15);
        check("post_rst_clear", rd_do, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
